// File: rtl/req_pkg.sv
// Shared types and sizes for the request front-end.
package req_pkg;

   localparam int NUM_REQ = 4;
   localparam int CODE_W  = 2;

   typedef logic [NUM_REQ-1:0] req_vec_t;
   typedef logic [CODE_W-1:0]  req_code_t;

endpackage

// File: rtl/req_line_debounce.sv
// One request line: two-flop synchroniser followed by a stability-count
// debouncer. o_rise is a one-cycle pulse in the cycle whose closing edge
// flips the filtered value from 0 to 1. It is decoded from registers only,
// so the consumer can capture the event on that same edge.
module req_line_debounce #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_rise
);

   localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_filt;
   logic [CNT_W-1:0] r_cnt;

   logic w_mismatch;
   logic w_done;

   assign w_mismatch = r_sync2 ^ r_filt;
   assign w_done     = w_mismatch && (r_cnt == CNT_LAST);
   assign o_rise     = w_done && !r_filt;

   // Synchronise the raw line, then only accept a new level once it has
   // disagreed with the filtered value for DB_CYCLES consecutive cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_filt  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (!w_mismatch) begin
            r_cnt <= '0;
         end else if (w_done) begin
            r_filt <= ~r_filt;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/req_debounce_latch.sv
// Front-end for the 4-to-2 priority encoder: debounces each request line,
// latches rising edges as sticky pending bits, clears them on a coded ack
// and flags edges that land on a still-pending bit.
module req_debounce_latch
   import req_pkg::*;
#(
   parameter int DB_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] raw_req,
   output logic [NUM_REQ-1:0] pend,
   output logic               pend_valid,
   input  logic               ack,
   input  logic [CODE_W-1:0]  ack_code,
   output logic [NUM_REQ-1:0] overflow,
   input  logic               ovf_clr
);

   req_vec_t r_pend;
   req_vec_t r_ovf;

   req_vec_t w_rise;
   req_vec_t w_clr;
   req_vec_t w_ovf_new;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_line
      req_line_debounce #(
         .DB_CYCLES (DB_CYCLES)
      ) u_line (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_raw  (raw_req[gi]),
         .o_rise (w_rise[gi])
      );
   end

   assign w_clr     = ack ? (req_vec_t'(1) << ack_code) : '0;
   // A new edge on an unserviced bit is lost unless the same edge services it.
   assign w_ovf_new = w_rise & r_pend & ~w_clr;

   // Pending bits: a new event wins over a simultaneous ack of the same line.
   // Overflow: a fresh loss wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_ovf  <= '0;
      end else begin
         r_pend <= w_rise | (r_pend & ~w_clr);
         r_ovf  <= (ovf_clr ? '0 : r_ovf) | w_ovf_new;
      end
   end

   assign pend       = r_pend;
   assign pend_valid = |r_pend;
   assign overflow   = r_ovf;

endmodule
